// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and SR/Cause field positions
// for the M-stage coprocessor-0 block.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 8;
  localparam int CAUSE_SW_LO = 8;

  // Address-error codes are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_count_compare.sv
// Free-running Count, Compare and the sticky timer-interrupt flag TI.
module cp0_count_compare (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] dataIn,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_we ? dataIn : count + 32'd1;
      // A Compare write in the matching cycle suppresses the set.
      if (compare_we) begin
        compare <= dataIn;
        ti      <= 1'b0;
      end else if ((count == compare) && (compare != '0)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_timer_ctrl.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId/BadVAddr, optional Count/Compare
// timer, and the exception/interrupt entry decision driving Req.
module cp0_timer_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0000,
  parameter bit          HAS_TIMER  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WE,
  input  logic [4:0]            regAddr,
  input  logic [31:0]           dataIn,
  input  logic [31:0]           PCnow,
  input  logic [31:0]           badAddrIn,
  input  logic [NUM_HW_INT-1:0] INTcodeIn,
  input  logic [4:0]            EXCcodeIn,
  input  logic                  if_delaybanch,
  input  logic                  if_eret,
  output logic [31:0]           EPCout,
  output logic [31:0]           dataOut,
  output logic                  Req,
  output logic                  timer_irq
);

  logic [31:0] sr, epc, badvaddr, count, compare, cause;
  logic [5:0]  int_ext, ip_hw_q;
  logic [1:0]  ip_sw;
  logic [7:0]  ip, pend;
  logic [4:0]  exc_code;
  logic        bd, ti, int_req, exc_req, wr;

  always_comb begin
    int_ext = '0;
    int_ext[NUM_HW_INT-1:0] = INTcodeIn;
  end

  // ti is tied low without the timer, so IP[15] degrades to the hw line.
  assign ip    = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw};
  assign pend  = ip & sr[SR_IM_LO +: 8];
  assign int_req = ~sr[SR_EXL] & sr[SR_IE] & (|pend);
  assign exc_req = ~sr[SR_EXL] & (EXCcodeIn != EXC_INT);
  assign Req     = int_req | exc_req;
  assign wr      = WE & ~Req;

  assign cause     = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b00};
  assign EPCout    = epc;
  assign timer_irq = ti;

  generate
    if (HAS_TIMER) begin : g_timer
      cp0_count_compare u_cc (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr && (regAddr == CP0_COUNT)),
        .compare_we (wr && (regAddr == CP0_COMPARE)),
        .dataIn     (dataIn),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
      );
    end else begin : g_no_timer
      assign count   = '0;
      assign compare = '0;
      assign ti      = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '0;
      epc      <= '0;
      badvaddr <= '0;
      ip_hw_q  <= '0;
      ip_sw    <= '0;
      exc_code <= '0;
      bd       <= 1'b0;
    end else begin
      ip_hw_q <= int_ext;
      if (Req) begin
        exc_code    <= int_req ? EXC_INT : EXCcodeIn;
        sr[SR_EXL]  <= 1'b1;
        bd          <= if_delaybanch;
        epc         <= if_delaybanch ? PCnow - 32'd4 : PCnow;
        if (!int_req && is_addr_exc(EXCcodeIn))
          badvaddr <= badAddrIn;
      end else begin
        if (wr && (regAddr == CP0_SR))    sr    <= dataIn;
        // Later assignment: eret's EXL clear lands on top of an SR write.
        if (if_eret)                      sr[SR_EXL] <= 1'b0;
        if (wr && (regAddr == CP0_CAUSE)) ip_sw <= dataIn[CAUSE_SW_LO +: 2];
        if (wr && (regAddr == CP0_EPC))   epc   <= {dataIn[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    dataOut = '0;
    case (regAddr)
      CP0_BADVADDR: dataOut = badvaddr;
      CP0_COUNT:    dataOut = count;
      CP0_COMPARE:  dataOut = compare;
      CP0_SR:       dataOut = sr;
      CP0_CAUSE:    dataOut = cause;
      CP0_EPC:      dataOut = epc;
      CP0_PRID:     dataOut = PRID_VALUE;
      default:      dataOut = '0;
    endcase
  end

endmodule
